// File: rtl/sdr_cmd_sched_pkg.sv
// Shared types and timing defaults for the SDRAM command-phase scheduler.
//   cmd_state_t  : command state presented to sdr_ctrl_sig
//   init_state_t : init sequencer states (i_ready gates host traffic)
//   *_DEF        : default timing in pclk cycles
package sdr_cmd_sched_pkg;

  localparam int CA_LSB     = 0;
  localparam int RA_MSB     = 23;
  localparam int ADDR_W_DEF = RA_MSB - CA_LSB + 1;

  localparam int TRCD_DEF   = 2;
  localparam int CAS_DEF    = 2;
  localparam int BL_DEF     = 4;
  localparam int TRFC_DEF   = 7;
  localparam int TREC_DEF   = 3;
  localparam int REFI_DEF   = 1560;

  typedef enum logic [3:0] {
    c_idle   = 4'd0,
    c_ACTIVE = 4'd1,
    c_tRCD   = 4'd2,
    c_READA  = 4'd3,
    c_cl     = 4'd4,
    c_rdata  = 4'd5,
    c_WRITEA = 4'd6,
    c_wdata  = 4'd7,
    c_AR     = 4'd8,
    c_tRFC   = 4'd9
  } cmd_state_t;

  typedef enum logic [2:0] {
    i_nop   = 3'd0,
    i_pre   = 3'd1,
    i_ar1   = 3'd2,
    i_ar2   = 3'd3,
    i_mrs   = 3'd4,
    i_ready = 3'd5
  } init_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdr_cmd_sched_ref_timer.sv
// Periodic auto-refresh request generator.
//   pclk, preset : clock, async active-high reset
//   en           : count enable (init_done); timer frozen while low
//   ack          : scheduler has issued c_AR for the pending request
//   ref_req      : refresh pending
//   ref_overrun  : sticky, an interval expired while a request was still pending
module sdr_ref_timer #(
  parameter int REF_INTERVAL = 1560
) (
  input  logic pclk,
  input  logic preset,
  input  logic en,
  input  logic ack,
  output logic ref_req,
  output logic ref_overrun
);

  localparam int T_W = $clog2(REF_INTERVAL + 1);
  localparam logic [T_W-1:0] RELOAD = T_W'(REF_INTERVAL - 1);

  logic [T_W-1:0] tmr;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tmr         <= RELOAD;
      ref_req     <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (ack) ref_req <= 1'b0;
      if (en) begin
        if (tmr == '0) begin
          tmr     <= RELOAD;
          // A new expiry overrides a same-cycle ack; requests do not queue.
          ref_req <= 1'b1;
          if (ref_req && !ack) ref_overrun <= 1'b1;
        end else begin
          tmr <= tmr - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdr_cmd_sched.sv
// SDRAM command-phase scheduler between the host port and sdr_ctrl_sig.
// One host access at a time: ACTIVE -> tRCD -> READA/WRITEA -> CL/data.
// Periodic auto-refresh wins over a host request in idle.
//   pclk, preset           : clock, async active-high reset
//   init_done              : init sequencer reached i_ready
//   psel/penable/pwrite/paddr : host request, held until pready
//   pready                 : one-cycle pulse on the last data beat
//   cmd_addr               : address latched at accept
//   cState                 : command state to sdr_ctrl_sig
//   rd_valid / wr_strobe   : read beat / write command+beat qualifiers
//   busy                   : not idle or still recovering
//   ref_overrun            : sticky refresh overrun flag
module sdr_cmd_sched
  import sdr_cmd_sched_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int tRCD_CYC     = TRCD_DEF,
  parameter int CAS_LAT      = CAS_DEF,
  parameter int BURST_LEN    = BL_DEF,
  parameter int tRFC_CYC     = TRFC_DEF,
  parameter int tREC_CYC     = TREC_DEF,
  parameter int REF_INTERVAL = REFI_DEF
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              init_done,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  output logic              pready,
  output logic [ADDR_W-1:0] cmd_addr,
  output cmd_state_t        cState,
  output logic              rd_valid,
  output logic              wr_strobe,
  output logic              busy,
  output logic              ref_overrun
);

  localparam int PH_MAX = max2(max2(tRCD_CYC, CAS_LAT), max2(BURST_LEN, tRFC_CYC));
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int REC_W  = $clog2(tREC_CYC + 1) + 1;

  typedef logic [PH_W-1:0]  ph_t;
  typedef logic [REC_W-1:0] rec_t;

  // A phase of N cycles loads N-1 on entry and exits when the counter is 0.
  localparam ph_t TRCD_LD = ph_t'((tRCD_CYC  > 1) ? tRCD_CYC  - 2 : 0);
  localparam ph_t CL_LD   = ph_t'((CAS_LAT   > 1) ? CAS_LAT   - 2 : 0);
  localparam ph_t RD_LD   = ph_t'(BURST_LEN - 1);
  localparam ph_t WD_LD   = ph_t'((BURST_LEN > 1) ? BURST_LEN - 2 : 0);
  localparam ph_t RFC_LD  = ph_t'((tRFC_CYC  > 1) ? tRFC_CYC  - 2 : 0);
  // The first idle cycle after an access is already a recovery cycle, so the
  // counter holds the recovery cycles still owed after the current one.
  localparam rec_t REC_LD = rec_t'((tREC_CYC > 0) ? tREC_CYC - 1 : 0);

  cmd_state_t state;
  ph_t        ph_cnt;
  rec_t       rec_cnt;
  logic       is_wr;
  logic       ref_req;
  logic       rec_zero;
  logic       ref_ack;
  logic       accept;

  assign cState   = state;
  assign rec_zero = (rec_cnt == '0);
  assign ref_ack  = (state == c_idle) & ref_req & init_done & rec_zero;
  assign accept   = (state == c_idle) & init_done & rec_zero & ~ref_req
                  & psel & penable & ~pready;

  sdr_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .pclk        (pclk),
    .preset      (preset),
    .en          (init_done),
    .ack         (ref_ack),
    .ref_req     (ref_req),
    .ref_overrun (ref_overrun)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= c_idle;
      ph_cnt    <= '0;
      rec_cnt   <= '0;
      is_wr     <= 1'b0;
      cmd_addr  <= '0;
      pready    <= 1'b0;
      rd_valid  <= 1'b0;
      wr_strobe <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        c_idle: begin
          if (ref_ack) begin
            state <= c_AR;
            busy  <= 1'b1;
          end else if (accept) begin
            state    <= c_ACTIVE;
            busy     <= 1'b1;
            cmd_addr <= paddr;
            is_wr    <= pwrite;
          end else if (!rec_zero) begin
            rec_cnt <= rec_cnt - 1'b1;
            busy    <= (rec_cnt != rec_t'(1));
          end else begin
            busy <= 1'b0;
          end
        end

        c_ACTIVE: begin
          if (tRCD_CYC > 1) begin
            state  <= c_tRCD;
            ph_cnt <= TRCD_LD;
          end else if (is_wr) begin
            state     <= c_WRITEA;
            wr_strobe <= 1'b1;
            pready    <= (BURST_LEN == 1);
          end else begin
            state <= c_READA;
          end
        end

        c_tRCD: begin
          if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - 1'b1;
          end else if (is_wr) begin
            state     <= c_WRITEA;
            wr_strobe <= 1'b1;
            pready    <= (BURST_LEN == 1);
          end else begin
            state <= c_READA;
          end
        end

        c_READA: begin
          if (CAS_LAT > 1) begin
            state  <= c_cl;
            ph_cnt <= CL_LD;
          end else begin
            state    <= c_rdata;
            ph_cnt   <= RD_LD;
            rd_valid <= 1'b1;
            pready   <= (BURST_LEN == 1);
          end
        end

        c_cl: begin
          if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - 1'b1;
          end else begin
            state    <= c_rdata;
            ph_cnt   <= RD_LD;
            rd_valid <= 1'b1;
            pready   <= (BURST_LEN == 1);
          end
        end

        c_rdata: begin
          if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - 1'b1;
            pready <= (ph_cnt == ph_t'(1));
          end else begin
            state    <= c_idle;
            rd_valid <= 1'b0;
            pready   <= 1'b0;
            rec_cnt  <= REC_LD;
            busy     <= (REC_LD != '0);
          end
        end

        c_WRITEA: begin
          if (BURST_LEN > 1) begin
            state  <= c_wdata;
            ph_cnt <= WD_LD;
            pready <= (BURST_LEN == 2);
          end else begin
            state     <= c_idle;
            wr_strobe <= 1'b0;
            pready    <= 1'b0;
            rec_cnt   <= REC_LD;
            busy      <= (REC_LD != '0);
          end
        end

        c_wdata: begin
          if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - 1'b1;
            pready <= (ph_cnt == ph_t'(1));
          end else begin
            state     <= c_idle;
            wr_strobe <= 1'b0;
            pready    <= 1'b0;
            rec_cnt   <= REC_LD;
            busy      <= (REC_LD != '0);
          end
        end

        c_AR: begin
          if (tRFC_CYC > 1) begin
            state  <= c_tRFC;
            ph_cnt <= RFC_LD;
          end else begin
            state <= c_idle;
            busy  <= 1'b0;
          end
        end

        // Refresh never loads recovery; idle was entered with rec_cnt==0.
        c_tRFC: begin
          if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - 1'b1;
          end else begin
            state <= c_idle;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= c_idle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
